// File: rtl/mmio_game_io.sv
// mmio_game_io -- memory-mapped game I/O block: random number source,
// debounced button event FIFO, LED control and tone control.
//
// Word address map, relative to BASE_ADDR:
//   +0  read   current 32-bit LFSR word (no side effects)
//   +1  read   event pop: {valid, overflow, 22'b0, remaining[3:0], 1'b0, index[2:0]}
//              (the FIFO only pops when rden=1)
//   +2  write  LED control: data_in[3:1] = channel, data_in[0] = on/off
//   +3  write  tone control: data_in[3:1] = tone_sel, data_in[0] = tone_on
//
// Ports:
//   clock, reset      sole clock (rising edge), asynchronous active-low reset
//   wren, rden        processor write strobe and single-cycle read strobe
//   address, data_in  12-bit word address and 32-bit write data
//   q_out, hit        registered read data and address-hit flag, one cycle later
//   buttons           raw asynchronous active-high button inputs
//   leds              active-high LED drive
//   tone_sel, tone_on selected tone index and tone enable
//
// Optional feature macro: MMIO_GAME_IO_FLASH_TIMER_EN
//   defined   -> an LED-on write starts a per-channel FLASH_CYCLES timer and the
//                LED turns itself off when it expires
//   undefined -> LEDs hold until written off; no timers are built
module mmio_game_io #(
   parameter int          NUM_CH          = 4,
   parameter logic [11:0] BASE_ADDR       = 12'd5,
   parameter int          FIFO_DEPTH      = 4,
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter int          FLASH_CYCLES    = 25000000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wren,
   input  logic              rden,
   input  logic [11:0]       address,
   input  logic [31:0]       data_in,
   output logic [31:0]       q_out,
   output logic              hit,
   input  logic [NUM_CH-1:0] buttons,
   output logic [NUM_CH-1:0] leds,
   output logic [2:0]        tone_sel,
   output logic              tone_on
);

   localparam int              AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int              CW        = AW + 1;
   localparam int              DW        = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0]   DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   FIFO_FULL = CW'(FIFO_DEPTH);
   localparam logic [3:0]      NUM_CH_L  = 4'(NUM_CH);
   // x^32 + x^22 + x^2 + x + 1 in right-shifting Galois form
   localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
   localparam int              FW         = $clog2(FLASH_CYCLES + 1);
   localparam logic [FW-1:0]   FLASH_LOAD = FW'(FLASH_CYCLES);
`endif

   // One LFSR step; a zero result is forced back to the seed so the lock-up
   // state can never persist even after an upset.
   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      logic [31:0] n;
      if (s[0]) begin
         n = {1'b0, s[31:1]} ^ LFSR_TAPS;
      end else begin
         n = {1'b0, s[31:1]};
      end
      if (n == 32'h0) begin
         return 32'h1;
      end else begin
         return n;
      end
   endfunction

   logic [31:0]       lfsr_q, lfsr_d;
   logic [NUM_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NUM_CH-1:0] deb_q, deb_d;
   logic [DW-1:0]     db_cnt_q [NUM_CH];
   logic [DW-1:0]     db_cnt_d [NUM_CH];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [2:0]        fifo_mem_q [FIFO_DEPTH];
   logic [2:0]        fifo_mem_d [FIFO_DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [NUM_CH-1:0] leds_q, leds_d;
   logic [2:0]        tone_sel_q, tone_sel_d;
   logic              tone_on_q, tone_on_d;
   logic [31:0]       q_out_q, q_out_d;
   logic              hit_q, hit_d;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
   logic [FW-1:0]     flash_cnt_q [NUM_CH];
   logic [FW-1:0]     flash_cnt_d [NUM_CH];
`endif

   logic              in_range;
   logic [1:0]        offset;
   logic              rd_evt, wr_led, wr_tone, wr_ch_ok;
   logic [2:0]        wr_ch;
   logic              push_req, push, pop, drop, fifo_valid;
   logic [2:0]        sel_ch, head;
   logic [NUM_CH-1:0] clear_mask, rise;
   logic [3:0]        remaining;
   logic [31:0]       evt_word;
   logic              unused_data;

   assign unused_data = ^data_in[31:4];

   // Next-state logic for every register in the block.
   always_comb begin
      // address decode; 13-bit compare so a base near the top cannot wrap
      in_range = ({1'b0, address} >= {1'b0, BASE_ADDR}) &&
                 ({1'b0, address} <= ({1'b0, BASE_ADDR} + 13'd3));
      offset   = 2'(address - BASE_ADDR);
      rd_evt   = rden && in_range && (offset == 2'd1);
      wr_led   = wren && in_range && (offset == 2'd2);
      wr_tone  = wren && in_range && (offset == 2'd3);
      wr_ch    = data_in[3:1];
      wr_ch_ok = ({1'b0, wr_ch} < NUM_CH_L);

      lfsr_d   = lfsr_next(lfsr_q);
      sync1_d  = buttons;
      sync2_d  = sync1_q;

      // debounce: level flips only after DEBOUNCE_CYCLES differing cycles in a row
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) begin
               deb_d[i]    = sync2_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
      rise = deb_d & ~deb_q;

      // lowest-index pending channel is the push candidate this cycle
      push_req = |pending_q;
      sel_ch   = 3'd0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel_ch = 3'(i);
         end else begin
            sel_ch = sel_ch;
         end
      end
      clear_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (push_req && (sel_ch == 3'(i))) begin
            clear_mask[i] = 1'b1;
         end else begin
            clear_mask[i] = 1'b0;
         end
      end
      pending_d = (pending_q & ~clear_mask) | rise;

      // FIFO: a pop frees a slot in the same cycle, so push at full succeeds then
      fifo_valid = (count_q != '0);
      pop        = rd_evt && fifo_valid;
      push       = push_req && ((count_q != FIFO_FULL) || pop);
      drop       = push_req && (count_q == FIFO_FULL) && !pop;
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = sel_ch;
         wr_ptr_d             = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (drop) begin
         ovf_d = 1'b1;
      end else if (rd_evt) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end

      // event word reflects the state before this cycle's pop
      if (fifo_valid) begin
         head      = fifo_mem_q[rd_ptr_q];
         remaining = 4'(count_q - CW'(1));
      end else begin
         head      = 3'd0;
         remaining = 4'd0;
      end
      evt_word = {fifo_valid, ovf_q, 22'd0, remaining, 1'b0, head};

      // LED control
      leds_d = leds_q;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
      flash_cnt_d = flash_cnt_q;
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_led && wr_ch_ok && (wr_ch == 3'(i))) begin
            leds_d[i]      = data_in[0];
            flash_cnt_d[i] = data_in[0] ? FLASH_LOAD : '0;
         end else if (flash_cnt_q[i] != '0) begin
            flash_cnt_d[i] = flash_cnt_q[i] - FW'(1);
            if (flash_cnt_q[i] == FW'(1)) begin
               leds_d[i] = 1'b0;
            end else begin
               leds_d[i] = leds_q[i];
            end
         end else begin
            leds_d[i] = leds_q[i];
         end
      end
`else
      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_led && wr_ch_ok && (wr_ch == 3'(i))) begin
            leds_d[i] = data_in[0];
         end else begin
            leds_d[i] = leds_q[i];
         end
      end
`endif

      // tone control
      if (wr_tone) begin
         tone_sel_d = data_in[3:1];
         tone_on_d  = data_in[0];
      end else begin
         tone_sel_d = tone_sel_q;
         tone_on_d  = tone_on_q;
      end

      // registered read path
      hit_d = in_range;
      if (in_range) begin
         case (offset)
            2'd0:    q_out_d = lfsr_q;
            2'd1:    q_out_d = evt_word;
            default: q_out_d = 32'h0;
         endcase
      end else begin
         q_out_d = 32'h0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q     <= 32'h1;
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         pending_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         leds_q     <= '0;
         tone_sel_q <= 3'd0;
         tone_on_q  <= 1'b0;
         q_out_q    <= 32'h0;
         hit_q      <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            db_cnt_q[i] <= '0;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
            flash_cnt_q[i] <= '0;
`endif
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= 3'd0;
         end
      end else begin
         lfsr_q      <= lfsr_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         db_cnt_q    <= db_cnt_d;
         pending_q   <= pending_d;
         fifo_mem_q  <= fifo_mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         leds_q      <= leds_d;
         tone_sel_q  <= tone_sel_d;
         tone_on_q   <= tone_on_d;
         q_out_q     <= q_out_d;
         hit_q       <= hit_d;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
         flash_cnt_q <= flash_cnt_d;
`endif
      end
   end

   assign q_out    = q_out_q;
   assign hit      = hit_q;
   assign leds     = leds_q;
   assign tone_sel = tone_sel_q;
   assign tone_on  = tone_on_q;

endmodule

// File: tb/tb_mmio_game_io.sv
// Testbench for mmio_game_io: randomized and directed stimulus checked against
// a behavioural model (event queue, LED/tone state, LFSR derived from its
// polynomial and the number of clock edges since reset release).
module tb_mmio_game_io;

   localparam int          NUM_CH = 4;
   localparam logic [11:0] BASE   = 12'd5;
   localparam int          DEPTH  = 4;
   localparam int          DB     = 4;
   localparam int          FL     = 8;

   logic              clock;
   logic              reset;
   logic              wren;
   logic              rden;
   logic [11:0]       address;
   logic [31:0]       data_in;
   logic [31:0]       q_out;
   logic              hit;
   logic [NUM_CH-1:0] buttons;
   logic [NUM_CH-1:0] leds;
   logic [2:0]        tone_sel;
   logic              tone_on;

   int checks = 0;
   int passed = 0;
   int edges  = 0;

   // model state
   int         evq[$];
   bit         m_ovf;
   bit         m_led [NUM_CH];
   int         m_fl  [NUM_CH];
   logic [2:0] m_tone_sel;
   bit         m_tone_on;

   mmio_game_io #(
      .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH),
      .DEBOUNCE_CYCLES(DB), .FLASH_CYCLES(FL)
   ) dut (
      .clock(clock), .reset(reset), .wren(wren), .rden(rden),
      .address(address), .data_in(data_in), .q_out(q_out), .hit(hit),
      .buttons(buttons), .leds(leds), .tone_sel(tone_sel), .tone_on(tone_on)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // clock edges seen with reset released
   always @(posedge clock or negedge reset) begin
      if (!reset) edges <= 0;
      else        edges <= edges + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // LFSR state after n steps from seed 1, taps built from the polynomial exponents
   function automatic logic [31:0] lfsr_at(input int n);
      logic [31:0] s, taps;
      taps = (32'h1 << 31) | (32'h1 << 21) | (32'h1 << 1) | (32'h1 << 0);
      s = 32'h1;
      for (int k = 0; k < n; k++) s = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
      return s;
   endfunction

   function automatic logic [31:0] evt_word();
      if (evq.size() > 0)
         return {1'b1, m_ovf, 22'd0, 4'(evq.size() - 1), 1'b0, 3'(evq[0])};
      else
         return {1'b0, m_ovf, 30'd0};
   endfunction

   function automatic void model_pop();
      if (evq.size() > 0) void'(evq.pop_front());
      m_ovf = 1'b0;
   endfunction

   function automatic void model_event(input int ch);
      if (evq.size() < DEPTH) evq.push_back(ch);
      else m_ovf = 1'b1;
   endfunction

   function automatic void model_reset();
      evq.delete();
      m_ovf = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin m_led[c] = 1'b0; m_fl[c] = 0; end
      m_tone_sel = 3'd0;
      m_tone_on  = 1'b0;
   endfunction

   function automatic logic [NUM_CH-1:0] m_leds();
      logic [NUM_CH-1:0] r;
      for (int c = 0; c < NUM_CH; c++) r[c] = m_led[c];
      return r;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_pop(output logic [31:0] v);
      address = BASE + 12'd1;
      rden = 1'b1;
      tick();
      v = q_out;
      rden = 1'b0;
      address = 12'd0;
   endtask

   task automatic press(input logic [NUM_CH-1:0] mask);
      buttons = mask;
      repeat (10) tick();
      buttons = '0;
      repeat (10) tick();
      for (int c = 0; c < NUM_CH; c++) if (mask[c]) model_event(c);
   endtask

   // one bus cycle, with the LED/tone/event model advanced alongside
   task automatic bus_cycle(input logic w, input logic r, input logic [11:0] a,
                            input logic [31:0] d);
      int ch;
      address = a; wren = w; rden = r; data_in = d;
      tick();
      wren = 1'b0; rden = 1'b0; address = 12'd0;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
      for (int c = 0; c < NUM_CH; c++) begin
         if (m_fl[c] > 0) begin
            m_fl[c]--;
            if (m_fl[c] == 0) m_led[c] = 1'b0;
         end
      end
`endif
      if (w && a == BASE + 12'd2) begin
         ch = int'(d[3:1]);
         if (ch < NUM_CH) begin
            m_led[ch] = d[0];
            m_fl[ch]  = d[0] ? FL : 0;
         end
      end
      if (w && a == BASE + 12'd3) begin
         m_tone_sel = d[3:1];
         m_tone_on  = d[0];
      end
      if (r && a == BASE + 12'd1) model_pop();
   endtask

   task automatic test_reset();
      reset = 1'b0; wren = 1'b0; rden = 1'b1; address = BASE;
      data_in = 32'h0; buttons = '0;
      model_reset();
      repeat (3) tick();
      checks++; if (q_out !== 32'h0) $display("FAIL reset_q_out got %h want 0", q_out); else passed++;
      checks++; if (hit !== 1'b0) $display("FAIL reset_hit got %b want 0", hit); else passed++;
      checks++; if (leds !== '0) $display("FAIL reset_leds got %b want 0", leds); else passed++;
      checks++; if (tone_sel !== 3'd0) $display("FAIL reset_tone_sel got %0d want 0", tone_sel); else passed++;
      checks++; if (tone_on !== 1'b0) $display("FAIL reset_tone_on got %b want 0", tone_on); else passed++;
      rden = 1'b0; address = 12'd0;
      reset = 1'b1;
   endtask

   task automatic test_lfsr();
      logic [31:0] v1, v2, e;
      address = BASE; rden = 1'b1;
      tick();
      v1 = q_out; e = lfsr_at(edges - 1);
      checks++; if (v1 !== e || v1 !== 32'h1) $display("FAIL lfsr_first got %h want %h", v1, e); else passed++;
      checks++; if (hit !== 1'b1) $display("FAIL lfsr_hit got %b want 1", hit); else passed++;
      tick();
      v2 = q_out; e = lfsr_at(edges - 1);
      checks++; if (v2 !== e) $display("FAIL lfsr_second got %h want %h", v2, e); else passed++;
      checks++; if (v2 === v1 || v2 === 32'h0) $display("FAIL lfsr_distinct got %h want nonzero and not %h", v2, v1); else passed++;
      rden = 1'b0; address = 12'd0;
   endtask

   task automatic test_single_press();
      logic [31:0] v, e;
      press(4'b0100);
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'h8000_0002) $display("FAIL single_pop got %h want %h", v, e); else passed++;
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'h0) $display("FAIL single_empty got %h want %h", v, e); else passed++;
   endtask

   task automatic test_two_press();
      logic [31:0] v, e;
      press(4'b1001);
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'h8000_0010) $display("FAIL two_pop0 got %h want %h", v, e); else passed++;
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'h8000_0003) $display("FAIL two_pop1 got %h want %h", v, e); else passed++;
   endtask

   task automatic test_overflow();
      logic [31:0] v, e;
      press(4'b1111);
      press(4'b0011);
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'hC000_0030) $display("FAIL ovf_pop got %h want %h", v, e); else passed++;
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v[30] !== 1'b0) $display("FAIL ovf_cleared got %h want %h", v, e); else passed++;
      while (evq.size() > 0) begin
         e = evt_word(); do_pop(v); model_pop();
         checks++; if (v !== e) $display("FAIL ovf_drain got %h want %h", v, e); else passed++;
      end
   endtask

   task automatic test_random_events();
      logic [31:0] v, e;
      int n, k;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(1, 2);
         repeat (n) press(4'($urandom_range(1, 15)));
         k = evq.size() + 1;
         for (int j = 0; j < k; j++) begin
            e = evt_word(); do_pop(v); model_pop();
            checks++; if (v !== e) $display("FAIL rand_evt it%0d pop%0d got %h want %h", it, j, v, e); else passed++;
         end
      end
   endtask

   task automatic test_bounce_and_reset();
      logic [31:0] v, e;
      for (int i = 0; i < 20; i++) begin
         buttons = (i % 2 == 0) ? 4'b0010 : 4'b0000;
         tick();
      end
      buttons = '0;
      repeat (10) tick();
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'h0) $display("FAIL bounce_no_event got %h want %h", v, e); else passed++;
      buttons = 4'b0001;
      repeat (4) tick();
      bus_cycle(1'b1, 1'b0, BASE + 12'd2, 32'h1);
      checks++; if (leds !== 4'b0001) $display("FAIL midhold_led got %b want 0001", leds); else passed++;
      reset = 1'b0;
      #1;
      model_reset();
      checks++; if (leds !== '0) $display("FAIL midreset_leds got %b want 0", leds); else passed++;
      checks++; if (q_out !== 32'h0 || hit !== 1'b0) $display("FAIL midreset_read got %h/%b want 0/0", q_out, hit); else passed++;
      repeat (2) tick();
      reset = 1'b1;
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e) $display("FAIL postreset_empty got %h want %h", v, e); else passed++;
      repeat (10) tick();
      buttons = '0;
      repeat (10) tick();
      model_event(0);
      e = evt_word(); do_pop(v); model_pop();
      checks++; if (v !== e || v !== 32'h8000_0000) $display("FAIL postreset_event got %h want %h", v, e); else passed++;
   endtask

   task automatic test_leds();
      bus_cycle(1'b1, 1'b0, BASE + 12'd2, 32'h5);
      checks++; if (leds !== m_leds() || leds !== 4'b0100) $display("FAIL led_on got %b want %b", leds, m_leds()); else passed++;
`ifdef MMIO_GAME_IO_FLASH_TIMER_EN
      for (int i = 0; i < 7; i++) begin
         bus_cycle(1'b0, 1'b0, 12'd0, 32'h0);
         checks++; if (leds !== 4'b0100) $display("FAIL led_flash_hold%0d got %b want 0100", i, leds); else passed++;
      end
      bus_cycle(1'b0, 1'b0, 12'd0, 32'h0);
      checks++; if (leds !== 4'b0000 || leds !== m_leds()) $display("FAIL led_flash_expire got %b want 0000", leds); else passed++;
`else
      repeat (99) bus_cycle(1'b0, 1'b0, 12'd0, 32'h0);
      checks++; if (leds !== 4'b0100) $display("FAIL led_hold100 got %b want 0100", leds); else passed++;
      bus_cycle(1'b1, 1'b0, BASE + 12'd2, 32'h4);
      checks++; if (leds !== 4'b0000) $display("FAIL led_off got %b want 0000", leds); else passed++;
`endif
      bus_cycle(1'b1, 1'b0, BASE + 12'd2, 32'h9);
      checks++; if (leds !== m_leds()) $display("FAIL led_bad_ch got %b want %b", leds, m_leds()); else passed++;
   endtask

   task automatic test_random_access();
      logic [11:0] a;
      logic        w, r, eh;
      logic [31:0] d, eq, ev;
      for (int i = 0; i < 150; i++) begin
         a  = 12'($urandom_range(0, 12));
         w  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         d  = $urandom;
         ev = evt_word();
         eh = (a >= BASE) && (a <= BASE + 12'd3);
         bus_cycle(w, r, a, d);
         if (a == BASE)              eq = lfsr_at(edges - 1);
         else if (a == BASE + 12'd1) eq = ev;
         else                        eq = 32'h0;
         checks++; if (q_out !== eq) $display("FAIL rnd_q_out i%0d a%0d got %h want %h", i, a, q_out, eq); else passed++;
         checks++; if (hit !== eh) $display("FAIL rnd_hit i%0d a%0d got %b want %b", i, a, hit, eh); else passed++;
         checks++; if (leds !== m_leds()) $display("FAIL rnd_leds i%0d got %b want %b", i, leds, m_leds()); else passed++;
         checks++; if (tone_sel !== m_tone_sel || tone_on !== m_tone_on)
            $display("FAIL rnd_tone i%0d got %0d/%b want %0d/%b", i, tone_sel, tone_on, m_tone_sel, m_tone_on);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_lfsr();
      test_single_press();
      test_two_press();
      test_overflow();
      test_random_events();
      test_bounce_and_reset();
      test_leds();
      test_random_access();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mmio_game_io.md
MMIO_GAME_IO -- requirements
Module: mmio_game_io

Interface
REQ-001 Parameter NUM_CH, default 4: number of button/LED channels, range 2..8.
REQ-002 Parameter BASE_ADDR, default 12'd5: first of four consecutive word addresses decoded.
REQ-003 Parameter FIFO_DEPTH, default 4: button-event FIFO depth, power of 2, range 2..16.
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000: number of stable cycles needed to accept a button level.
REQ-005 Parameter FLASH_CYCLES, default 25000000: LED on-time when the flash timer is compiled in.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 wren  in  1  write strobe from processor.
REQ-009 rden  in  1  single-cycle read strobe from processor.
REQ-010 address  in  12  word address.
REQ-011 data_in  in  32  write data.
REQ-012 q_out  out  32  read data, registered.
REQ-013 hit  out  1  registered; high when the previous cycle's address fell in BASE_ADDR..BASE_ADDR+3.
REQ-014 buttons  in  NUM_CH  raw, asynchronous, active-high button inputs.
REQ-015 leds  out  NUM_CH  LED drive, active-high.
REQ-016 tone_sel  out  3  selected tone index.
REQ-017 tone_on  out  1  tone enable.

Function
REQ-018 Address map: BASE+0 R = random word; BASE+1 R = event pop; BASE+2 W = LED control; BASE+3 W = tone control.
REQ-019 Read latency: q_out and hit SHALL be valid exactly 1 cycle after the address is presented; a non-decoded address SHALL give q_out=0 and hit=0.
REQ-020 Random source: 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advances every cycle; reads SHALL NOT perturb it, and the all-zero state SHALL be unreachable.
REQ-021 Each button input SHALL pass a 2-flop synchroniser followed by a per-channel counter; the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of a differing synchronised level.
REQ-022 A debounced 0->1 edge SHALL set a per-channel pending bit.
REQ-023 Each cycle, the lowest-index pending bit SHALL be cleared and its channel index pushed to the FIFO; at most one push per cycle.
REQ-024 When the FIFO is full and no pop occurs that cycle, the push SHALL be dropped, the pending bit cleared, and a sticky overflow flag set.
REQ-025 Event pop read (rden=1 at BASE+1) SHALL return bit31=valid, bit30=overflow, bits[7:4]=entries remaining after the pop, bits[3:0]=channel index; then it SHALL pop one entry and clear overflow.
REQ-026 An event pop read on an empty FIFO SHALL return valid=0 and index=0, and leave the FIFO unchanged.
REQ-027 A simultaneous push and pop at full SHALL both succeed, leaving the count unchanged.
REQ-028 Reads with rden=0, and reads at BASE+0, SHALL have no side effects.
REQ-029 LED write (wren=1 at BASE+2): data_in[3:1] = channel, data_in[0] = on/off; a channel >= NUM_CH SHALL be ignored.
REQ-030 Tone write (wren=1 at BASE+3): tone_sel <= data_in[3:1], tone_on <= data_in[0], one cycle after the write.
REQ-031 Writes to BASE+0 or BASE+1 SHALL be ignored.

Reset
REQ-032 While reset=0: LFSR=32'h1, FIFO empty, overflow=0, pending=0, debounced levels=0, counters=0, leds=0, tone_sel=0, tone_on=0, q_out=0, hit=0.
REQ-033 Reset asserted mid-debounce or mid-flash SHALL abort the operation immediately; no event is produced after release until a full debounce completes.

Configuration
REQ-034 Macro MMIO_GAME_IO_FLASH_TIMER_EN, defined: an LED-on write SHALL load a per-channel counter with FLASH_CYCLES, and the LED SHALL clear automatically when the count expires; a rewrite SHALL reload the counter; an off-write SHALL clear the LED and its counter.
REQ-035 Macro MMIO_GAME_IO_FLASH_TIMER_EN, undefined: LEDs SHALL hold their state until an explicit off-write, and no flash counters SHALL be synthesised.

Verification (DEBOUNCE_CYCLES=4, FLASH_CYCLES=8, defaults otherwise)
REQ-036 Release reset, then read BASE+0 on two consecutive cycles -> two different nonzero values; the first value after reset release follows seed 32'h1.
REQ-037 Hold buttons[2]=1 for 10 cycles, then pop -> q_out=32'h8000_0002; second pop -> q_out=0.
REQ-038 Press buttons 0 and 3 in the same cycle, then pop twice -> indices 0 then 3, remaining counts 1 then 0.
REQ-039 Produce 6 events with no pops, then pop -> bit31=1, bit30=1, remaining=3, oldest index returned; next pop -> bit30=0.
REQ-040 Write 32'h5 to BASE+2 -> leds=4'b0100 next cycle; with the flash timer compiled in, leds=0 after 8 cycles; with it compiled out, leds are still 4'b0100 at cycle 100.
REQ-041 Bounce buttons[1] with 1-cycle pulses for 20 cycles -> no event; assert reset mid-hold -> leds=0 and FIFO empty immediately.
